// File: rtl/pipeline_run_pkg.sv
// pipeline_run_pkg
// Shared types and helpers for the pipeline run controller.
//   run_state_t : controller state encoding
//   XLEN_DEF    : default writeback data width
//   sig_next()  : one step of the writeback signature (any width 5..64)
package pipeline_run_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RESET = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } run_state_t;

  // Values are carried in a 64-bit container so one function serves every
  // XLEN; bits at and above xlen are masked off and always return as zero.
  function automatic logic [63:0] sig_next(input logic [63:0]   sig,
                                           input logic [4:0]    rd,
                                           input logic [63:0]   data,
                                           input int unsigned   xlen);
    logic [63:0] mask;
    logic [63:0] rot;
    mask = '1;
    if (xlen < 64) mask = (64'd1 << xlen) - 64'd1;
    rot = ((sig << 1) | (sig >> (xlen - 1))) & mask;
    return rot ^ (data & mask) ^ {59'd0, rd};
  endfunction

endpackage

// File: rtl/wb_signature.sv
// wb_signature
// Retire counter and writeback signature register.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_clear        : synchronous clear of count and signature (wins over enable)
//   i_en           : writebacks are only observed while high
//   i_wb_valid/rd/data : core writeback port
//   o_retire       : a retire is being accepted on this cycle
//   o_count_inc    : retire count after this retire (saturating)
//   o_retire_count, o_signature : registered results
module wb_signature
  import pipeline_run_pkg::*;
#(
  parameter int CNT_W = 16,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_clear,
  input  logic             i_en,
  input  logic             i_wb_valid,
  input  logic [4:0]       i_wb_rd,
  input  logic [XLEN-1:0]  i_wb_data,
  output logic             o_retire,
  output logic [CNT_W-1:0] o_count_inc,
  output logic [CNT_W-1:0] o_retire_count,
  output logic [XLEN-1:0]  o_signature
);

  logic [CNT_W-1:0] r_count;
  logic [XLEN-1:0]  r_sig;
  logic [63:0]      w_sig_ext;
  logic [63:0]      w_data_ext;
  logic [63:0]      w_sig_upd;
  logic             w_unused_hi;

  // x0 writes never retire.
  assign o_retire    = i_en & i_wb_valid & (i_wb_rd != 5'd0);
  assign o_count_inc = (r_count == '1) ? r_count : r_count + CNT_W'(1);

  always_comb begin
    w_sig_ext              = '0;
    w_sig_ext[XLEN-1:0]    = r_sig;
    w_data_ext             = '0;
    w_data_ext[XLEN-1:0]   = i_wb_data;
  end

  assign w_sig_upd   = sig_next(w_sig_ext, i_wb_rd, w_data_ext, XLEN);
  assign w_unused_hi = ^w_sig_upd;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_count <= '0;
      r_sig   <= '0;
    end else if (i_clear) begin
      r_count <= '0;
      r_sig   <= '0;
    end else if (o_retire) begin
      r_count <= o_count_inc;
      r_sig   <= w_sig_upd[XLEN-1:0];
    end
  end

  assign o_retire_count = r_count;
  assign o_signature    = r_sig;

endmodule

// File: rtl/pipeline_run_ctrl.sv
// pipeline_run_ctrl
// Sequences the core reset, runs the core for a bounded number of cycles or
// until enough writebacks retire, then freezes it and reports status plus a
// writeback signature.
//   clk, rst (async active-low)
//   start                      : begin a run (accepted in IDLE/DONE only)
//   wb_valid, wb_rd, wb_data   : core writeback, observed in RUN only
//   core_rst_n                 : core reset, low except in RUN
//   running, done, timeout     : run status
//   retire_count, cycle_count, signature : run results, held in DONE
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | after reset, core held in reset, waiting for start
// S_RESET | core held in reset for RESET_CYCLES cycles
// S_RUN   | core released, counting cycles and retires
// S_DONE  | core frozen, results held, waiting for next start
module pipeline_run_ctrl
  import pipeline_run_pkg::*;
#(
  parameter int RESET_CYCLES  = 2,
  parameter int CYCLE_BUDGET  = 10,
  parameter int RETIRE_TARGET = 0,
  parameter int CNT_W         = 16,
  parameter int XLEN          = XLEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             wb_valid,
  input  logic [4:0]       wb_rd,
  input  logic [XLEN-1:0]  wb_data,
  output logic             core_rst_n,
  output logic             running,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] retire_count,
  output logic [CNT_W-1:0] cycle_count,
  output logic [XLEN-1:0]  signature
);

  if (RESET_CYCLES < 1) begin : g_bad_reset_cycles
    $error("RESET_CYCLES must be at least 1");
  end
  if (CYCLE_BUDGET < 1 || longint'(CYCLE_BUDGET) >= (longint'(1) << CNT_W)) begin : g_bad_budget
    $error("CYCLE_BUDGET must be at least 1 and fit in CNT_W bits");
  end
  if (RETIRE_TARGET < 0 || longint'(RETIRE_TARGET) >= (longint'(1) << CNT_W)) begin : g_bad_target
    $error("RETIRE_TARGET must fit in CNT_W bits");
  end
  if (XLEN < 5 || XLEN > 64) begin : g_bad_xlen
    $error("XLEN must be in 5..64");
  end

  localparam int               RST_W     = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES + 1) : 1;
  localparam logic [RST_W-1:0] RST_LOAD  = RST_W'(RESET_CYCLES);
  localparam logic [CNT_W-1:0] BUDGET_C  = CNT_W'(CYCLE_BUDGET);
  localparam logic [CNT_W-1:0] TARGET_C  = CNT_W'(RETIRE_TARGET);

  run_state_t       r_state;
  logic [RST_W-1:0] r_rst_cnt;
  logic [CNT_W-1:0] r_cycle_cnt;
  logic             r_core_rst_n;
  logic             r_running;
  logic             r_done;
  logic             r_timeout;

  run_state_t       w_state_nxt;
  logic [RST_W-1:0] w_rst_cnt_nxt;
  logic [CNT_W-1:0] w_cycle_nxt;
  logic [CNT_W-1:0] w_cycle_inc;
  logic             w_core_rst_n_nxt;
  logic             w_running_nxt;
  logic             w_done_nxt;
  logic             w_timeout_nxt;
  logic             w_clear;
  logic             w_run_en;
  logic             w_retire;
  logic [CNT_W-1:0] w_count_inc;
  logic             w_target_hit;
  logic             w_budget_hit;

  assign w_run_en     = (r_state == S_RUN);
  assign w_cycle_inc  = r_cycle_cnt + CNT_W'(1);
  assign w_target_hit = (RETIRE_TARGET != 0) && w_retire && (w_count_inc == TARGET_C);
  assign w_budget_hit = (w_cycle_inc == BUDGET_C);

  wb_signature #(
    .CNT_W (CNT_W),
    .XLEN  (XLEN)
  ) u_wb_signature (
    .i_clk          (clk),
    .i_rst_n        (rst),
    .i_clear        (w_clear),
    .i_en           (w_run_en),
    .i_wb_valid     (wb_valid),
    .i_wb_rd        (wb_rd),
    .i_wb_data      (wb_data),
    .o_retire       (w_retire),
    .o_count_inc    (w_count_inc),
    .o_retire_count (retire_count),
    .o_signature    (signature)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state      <= S_IDLE;
      r_rst_cnt    <= '0;
      r_cycle_cnt  <= '0;
      r_core_rst_n <= 1'b0;
      r_running    <= 1'b0;
      r_done       <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_rst_cnt    <= w_rst_cnt_nxt;
      r_cycle_cnt  <= w_cycle_nxt;
      r_core_rst_n <= w_core_rst_n_nxt;
      r_running    <= w_running_nxt;
      r_done       <= w_done_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  // Output flags are computed one cycle ahead and registered, so every
  // status output changes on the same edge as the state.
  always_comb begin
    w_state_nxt      = r_state;
    w_rst_cnt_nxt    = r_rst_cnt;
    w_cycle_nxt      = r_cycle_cnt;
    w_core_rst_n_nxt = 1'b0;
    w_running_nxt    = 1'b0;
    w_done_nxt       = r_done;
    w_timeout_nxt    = r_timeout;
    w_clear          = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (start) begin
          w_state_nxt   = S_RESET;
          w_rst_cnt_nxt = RST_LOAD;
          w_cycle_nxt   = '0;
          w_done_nxt    = 1'b0;
          w_timeout_nxt = 1'b0;
          w_clear       = 1'b1;
        end
      end
      S_RESET: begin
        if (r_rst_cnt == RST_W'(1)) begin
          w_state_nxt      = S_RUN;
          w_core_rst_n_nxt = 1'b1;
          w_running_nxt    = 1'b1;
        end else begin
          w_rst_cnt_nxt = r_rst_cnt - RST_W'(1);
        end
      end
      S_RUN: begin
        w_cycle_nxt = w_cycle_inc;
        // Target takes priority when both limits land on the same edge.
        if (w_target_hit || w_budget_hit) begin
          w_state_nxt   = S_DONE;
          w_done_nxt    = 1'b1;
          w_timeout_nxt = !w_target_hit && (RETIRE_TARGET != 0);
        end else begin
          w_core_rst_n_nxt = 1'b1;
          w_running_nxt    = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign core_rst_n  = r_core_rst_n;
  assign running     = r_running;
  assign done        = r_done;
  assign timeout     = r_timeout;
  assign cycle_count = r_cycle_cnt;

endmodule

// File: tb/tb_pipeline_run_ctrl.sv
module tb_pipeline_run_ctrl;

  localparam int RC = 2;
  localparam int BUD [4] = '{10, 10, 4, 4};
  localparam int TGT [4] = '{0, 3, 5, 1};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_rd = 5'd0;
  logic [31:0] wb_data = 32'd0;

  logic        o_core_rst_n [4];
  logic        o_running    [4];
  logic        o_done       [4];
  logic        o_timeout    [4];
  logic [15:0] o_retire     [4];
  logic [15:0] o_cycle      [4];
  logic [31:0] o_sig        [4];

  int total = 0;
  int bad   = 0;

  // time-since-start reference model
  bit          m_active  [4];
  bit          m_done    [4];
  bit          m_timeout [4];
  int          m_elapsed [4];
  int          m_cyc     [4];
  int          m_cnt     [4];
  logic [31:0] m_sig     [4];

  always #5 clk = ~clk;

  pipeline_run_ctrl u0 (
    .clk(clk), .rst(rst), .start(start), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .core_rst_n(o_core_rst_n[0]), .running(o_running[0]), .done(o_done[0]), .timeout(o_timeout[0]),
    .retire_count(o_retire[0]), .cycle_count(o_cycle[0]), .signature(o_sig[0]));

  pipeline_run_ctrl #(.RETIRE_TARGET(3)) u1 (
    .clk(clk), .rst(rst), .start(start), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .core_rst_n(o_core_rst_n[1]), .running(o_running[1]), .done(o_done[1]), .timeout(o_timeout[1]),
    .retire_count(o_retire[1]), .cycle_count(o_cycle[1]), .signature(o_sig[1]));

  pipeline_run_ctrl #(.RETIRE_TARGET(5), .CYCLE_BUDGET(4)) u2 (
    .clk(clk), .rst(rst), .start(start), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .core_rst_n(o_core_rst_n[2]), .running(o_running[2]), .done(o_done[2]), .timeout(o_timeout[2]),
    .retire_count(o_retire[2]), .cycle_count(o_cycle[2]), .signature(o_sig[2]));

  pipeline_run_ctrl #(.RETIRE_TARGET(1), .CYCLE_BUDGET(4)) u3 (
    .clk(clk), .rst(rst), .start(start), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .core_rst_n(o_core_rst_n[3]), .running(o_running[3]), .done(o_done[3]), .timeout(o_timeout[3]),
    .retire_count(o_retire[3]), .cycle_count(o_cycle[3]), .signature(o_sig[3]));

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      m_active[k]  = 1'b0;
      m_done[k]    = 1'b0;
      m_timeout[k] = 1'b0;
      m_elapsed[k] = 0;
      m_cyc[k]     = 0;
      m_cnt[k]     = 0;
      m_sig[k]     = 32'd0;
    end
  endtask

  task automatic model_step();
    bit retire;
    bit hit;
    if (!rst) begin
      model_clear();
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (!m_active[k] || m_done[k]) begin
          if (start) begin
            m_active[k]  = 1'b1;
            m_done[k]    = 1'b0;
            m_timeout[k] = 1'b0;
            m_elapsed[k] = 0;
            m_cyc[k]     = 0;
            m_cnt[k]     = 0;
            m_sig[k]     = 32'd0;
          end
        end else if (m_elapsed[k] < RC) begin
          m_elapsed[k]++;
        end else begin
          m_cyc[k]++;
          retire = wb_valid && (wb_rd != 5'd0);
          hit    = 1'b0;
          if (retire) begin
            if (m_cnt[k] < 65535) m_cnt[k]++;
            m_sig[k] = {m_sig[k][30:0], m_sig[k][31]} ^ wb_data ^ {27'd0, wb_rd};
            hit = (TGT[k] != 0) && (m_cnt[k] == TGT[k]);
          end
          if (hit || m_cyc[k] == BUD[k]) begin
            m_done[k]    = 1'b1;
            m_timeout[k] = (TGT[k] != 0) && !hit;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 4; k++) begin
      logic exp_run;
      exp_run = m_active[k] && !m_done[k] && (m_elapsed[k] >= RC);
      chk($sformatf("u%0d.core_rst_n", k), 64'(o_core_rst_n[k]), 64'(exp_run));
      chk($sformatf("u%0d.running", k),    64'(o_running[k]),    64'(exp_run));
      chk($sformatf("u%0d.done", k),       64'(o_done[k]),       64'(m_done[k]));
      chk($sformatf("u%0d.timeout", k),    64'(o_timeout[k]),    64'(m_timeout[k]));
      chk($sformatf("u%0d.retire", k),     64'(o_retire[k]),     64'(m_cnt[k]));
      chk($sformatf("u%0d.cycle", k),      64'(o_cycle[k]),      64'(m_cyc[k]));
      chk($sformatf("u%0d.signature", k),  64'(o_sig[k]),        64'(m_sig[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_run0(input int limit);
    int n = 0;
    while (o_running[0] !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("wait_running", 64'(o_running[0]), 64'(1));
  endtask

  task automatic wait_done0(input int limit);
    int n = 0;
    while (o_done[0] !== 1'b1 && n < limit) begin
      tick();
      n++;
    end
    chk("wait_done", 64'(o_done[0]), 64'(1));
  endtask

  function automatic bit model_busy();
    bit b = 1'b0;
    for (int k = 0; k < 4; k++) if (m_active[k] && !m_done[k]) b = 1'b1;
    return b;
  endfunction

  typedef struct { logic [4:0] rd; logic [31:0] data; } wb_t;

  initial begin
    int low_cyc;
    int run_cyc;
    wb_t seq [4];
    seq[0] = '{5'd5, 32'h0000_000A};
    seq[1] = '{5'd0, 32'hFFFF_FFFF};
    seq[2] = '{5'd6, 32'h0000_0014};
    seq[3] = '{5'd7, 32'h0000_001E};

    // power-on reset held for three cycles
    #1 rst = 1'b0;
    model_clear();
    #1 check_all();
    repeat (3) tick();
    rst = 1'b1;
    tick();

    // defaults, no writebacks
    start_pulse();
    low_cyc = 0;
    run_cyc = 0;
    for (int n = 0; n < 30 && o_done[0] !== 1'b1; n++) begin
      if (o_running[0] === 1'b1) run_cyc++;
      else if (o_core_rst_n[0] === 1'b0 && run_cyc == 0) low_cyc++;
      tick();
    end
    chk("reset_low_cycles", 64'(low_cyc), 64'(2));
    chk("run_cycles", 64'(run_cyc), 64'(10));
    chk("def_done", 64'(o_done[0]), 64'(1));
    chk("def_timeout", 64'(o_timeout[0]), 64'(0));
    chk("def_cycle", 64'(o_cycle[0]), 64'(10));
    chk("def_retire", 64'(o_retire[0]), 64'(0));
    chk("def_sig", 64'(o_sig[0]), 64'(0));

    // early stop on the third non-x0 retire
    start_pulse();
    wait_run0(5);
    for (int i = 0; i < 4; i++) begin
      wb_valid = 1'b1;
      wb_rd    = seq[i].rd;
      wb_data  = seq[i].data;
      tick();
    end
    wb_valid = 1'b0;
    chk("early_done", 64'(o_done[1]), 64'(1));
    chk("early_retire", 64'(o_retire[1]), 64'(3));
    chk("early_timeout", 64'(o_timeout[1]), 64'(0));
    chk("early_cycle", 64'(o_cycle[1]), 64'(4));
    chk("early_sig", 64'(o_sig[1]), 64'(32'h0000_0001));
    wait_done0(20);

    // budget timeout with two retires
    start_pulse();
    wait_run0(5);
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i < 2);
      wb_rd    = 5'(3 + i);
      wb_data  = $urandom;
      tick();
    end
    wb_valid = 1'b0;
    chk("budget_done", 64'(o_done[2]), 64'(1));
    chk("budget_timeout", 64'(o_timeout[2]), 64'(1));
    chk("budget_retire", 64'(o_retire[2]), 64'(2));
    wait_done0(20);

    // retire on the last budget cycle: target wins
    start_pulse();
    wait_run0(5);
    for (int i = 0; i < 4; i++) begin
      wb_valid = (i == 3);
      wb_rd    = 5'd9;
      wb_data  = $urandom;
      tick();
    end
    wb_valid = 1'b0;
    chk("simul_done", 64'(o_done[3]), 64'(1));
    chk("simul_timeout", 64'(o_timeout[3]), 64'(0));
    chk("simul_retire", 64'(o_retire[3]), 64'(1));
    chk("simul_cycle", 64'(o_cycle[3]), 64'(4));
    wait_done0(20);

    // randomized traffic including stray start pulses
    for (int r = 0; r < 6; r++) begin
      start_pulse();
      for (int c = 0; c < 20; c++) begin
        start    = ($urandom_range(0, 7) == 0);
        wb_valid = $urandom_range(0, 1) == 1;
        wb_rd    = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
        wb_data  = $urandom;
        tick();
      end
      start    = 1'b0;
      wb_valid = 1'b0;
      for (int n = 0; n < 30 && model_busy(); n++) tick();
      chk("random_settle", 64'(model_busy()), 64'(0));
    end

    // asynchronous reset in RUN cycle 3
    start_pulse();
    wait_run0(5);
    tick();
    tick();
    #2 rst = 1'b0;
    model_clear();
    #1 check_all();
    chk("async_cycle", 64'(o_cycle[0]), 64'(0));
    tick();
    rst = 1'b1;
    tick();

    // clean rerun with start ignored in RESET and RUN
    start_pulse();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_run0(5);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done0(20);
    chk("rerun_cycle", 64'(o_cycle[0]), 64'(10));

    // start from DONE clears status
    start_pulse();
    chk("restart_done_clr", 64'(o_done[0]), 64'(0));
    chk("restart_cycle_clr", 64'(o_cycle[0]), 64'(0));
    wait_done0(20);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
